// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Brief    : Synchronise, debounce and edge-detect two push-buttons, with
//            optional hold-to-auto-repeat, producing one-cycle up/down strobes.
// Revision : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int DB_CYCLES  = 2500000,
    parameter int RPT_EN     = 1,
    parameter int RPT_DELAY  = 62500000,
    parameter int RPT_PERIOD = 12500000,
    parameter int CNT_W      = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic up_raw,
    input  logic down_raw,
    output logic up_pulse,
    output logic down_pulse,
    output logic up_level,
    output logic down_level
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_db_last  = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_dly_last = CNT_W'(RPT_DELAY - 1);
    localparam logic [CNT_W-1:0] c_per_last = CNT_W'(RPT_PERIOD - 1);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    logic [1:0] w_raw;
    logic [1:0] w_want;
    logic [1:0] w_level;

    assign w_raw = {down_raw, up_raw};

    generate
        for (genvar g = 0; g < 2; g++) begin : g_ch
            logic             r_s1;
            logic             r_s2;
            logic             r_db;
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] r_rcnt;
            state_t           r_state;
            logic             w_flip;
            logic             w_rise;
            logic             w_fall;
            logic             w_want_ch;

            assign w_flip  = (r_s2 != r_db) && (r_cnt == c_db_last);
            assign w_rise  = w_flip && r_s2;
            assign w_fall  = w_flip && !r_s2;

            // Pulse request is decided from the same edge that flips db,
            // so the strobe lands in the cycle right after the flip.
            always_comb begin
                w_want_ch = 1'b0;
                case (r_state)
                    ST_IDLE:   w_want_ch = w_rise;
                    ST_HELD:   w_want_ch = (RPT_EN != 0) && !w_fall && (r_rcnt == c_dly_last);
                    ST_REPEAT: w_want_ch = !w_fall && (r_rcnt == c_per_last);
                    default:   w_want_ch = 1'b0;
                endcase
            end

            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_s1    <= 1'b0;
                    r_s2    <= 1'b0;
                    r_db    <= 1'b0;
                    r_cnt   <= '0;
                    r_rcnt  <= '0;
                    r_state <= ST_IDLE;
                end else begin
                    r_s1 <= w_raw[g];
                    r_s2 <= r_s1;

                    if (r_s2 == r_db) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_db_last) begin
                        r_db  <= r_s2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end

                    case (r_state)
                        ST_IDLE: begin
                            if (w_rise) begin
                                r_state <= ST_HELD;
                                r_rcnt  <= '0;
                            end
                        end
                        ST_HELD: begin
                            if (w_fall) begin
                                r_state <= ST_IDLE;
                                r_rcnt  <= '0;
                            end else if ((RPT_EN != 0) && (r_rcnt == c_dly_last)) begin
                                r_state <= ST_REPEAT;
                                r_rcnt  <= '0;
                            end else if (r_rcnt != c_dly_last) begin
                                // Holds at the delay limit when repeat is off.
                                r_rcnt <= r_rcnt + c_one;
                            end
                        end
                        ST_REPEAT: begin
                            if (w_fall) begin
                                r_state <= ST_IDLE;
                                r_rcnt  <= '0;
                            end else if (r_rcnt == c_per_last) begin
                                r_rcnt <= '0;
                            end else begin
                                r_rcnt <= r_rcnt + c_one;
                            end
                        end
                        default: begin
                            r_state <= ST_IDLE;
                            r_rcnt  <= '0;
                        end
                    endcase
                end
            end

            assign w_want[g]  = w_want_ch;
            assign w_level[g] = r_db;
        end
    endgenerate

    // Simultaneous requests cancel each other; channel state still advances.
    always_ff @(posedge clk) begin
        if (!rst) begin
            up_pulse   <= 1'b0;
            down_pulse <= 1'b0;
        end else begin
            up_pulse   <= w_want[0] & ~w_want[1];
            down_pulse <= w_want[1] & ~w_want[0];
        end
    end

    assign up_level   = w_level[0];
    assign down_level = w_level[1];

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// Bench for button_conditioner: two instances (repeat on / off) driven by the
// same stimulus and compared every cycle against a behavioural model.
module tb_button_conditioner;

    localparam int DB  = 4;
    localparam int DLY = 10;
    localparam int PER = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic up_raw = 1'b0;
    logic down_raw = 1'b0;
    logic up_pulse1, down_pulse1, up_level1, down_level1;
    logic up_pulse0, down_pulse0, up_level0, down_level0;

    int total = 0;
    int bad = 0;
    int up_cnt1, down_cnt1, up_cnt0, down_cnt0;

    // model state, index 0 = up, 1 = down
    bit m_s1[2], m_s2[2], m_lvl[2], m_w1[2], m_w0[2];
    int m_run[2], m_t[2];

    always #5 clk = ~clk;

    button_conditioner #(.DB_CYCLES(DB), .RPT_EN(1), .RPT_DELAY(DLY), .RPT_PERIOD(PER), .CNT_W(8)) dut_rpt (
        .clk(clk), .rst(rst), .up_raw(up_raw), .down_raw(down_raw),
        .up_pulse(up_pulse1), .down_pulse(down_pulse1),
        .up_level(up_level1), .down_level(down_level1)
    );

    button_conditioner #(.DB_CYCLES(DB), .RPT_EN(0), .RPT_DELAY(DLY), .RPT_PERIOD(PER), .CNT_W(8)) dut_one (
        .clk(clk), .rst(rst), .up_raw(up_raw), .down_raw(down_raw),
        .up_pulse(up_pulse0), .down_pulse(down_pulse0),
        .up_level(up_level0), .down_level(down_level0)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Pulse on the edge the level rises; with repeat, again at DLY and every
    // PER cycles after that while the level stays high.
    task automatic model_edge(input bit u, input bit d, input bit r);
        bit raw[2];
        bit rise, fall;
        raw[0] = u;
        raw[1] = d;
        for (int c = 0; c < 2; c++) begin
            if (!r) begin
                m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0;
                m_run[c] = 0; m_t[c] = -1; m_w1[c] = 0; m_w0[c] = 0;
            end else begin
                rise = 0;
                fall = 0;
                if (m_s2[c] != m_lvl[c]) m_run[c]++;
                else m_run[c] = 0;
                if (m_run[c] == DB) begin
                    m_lvl[c] = m_s2[c];
                    m_run[c] = 0;
                    rise = m_s2[c];
                    fall = !m_s2[c];
                end
                m_s2[c] = m_s1[c];
                m_s1[c] = raw[c];
                m_w1[c] = 0;
                m_w0[c] = 0;
                if (rise) begin
                    m_t[c] = 0;
                    m_w1[c] = 1;
                    m_w0[c] = 1;
                end else if (fall) begin
                    m_t[c] = -1;
                end else if (m_t[c] >= 0) begin
                    m_t[c]++;
                    m_w1[c] = (m_t[c] >= DLY) && ((m_t[c] - DLY) % PER == 0);
                end
            end
        end
    endtask

    task automatic cycle(input bit u, input bit d, input bit r);
        up_raw = u;
        down_raw = d;
        rst = r;
        @(posedge clk);
        model_edge(u, d, r);
        #1;
        check("rpt.up_pulse",   up_pulse1,   m_w1[0] & ~m_w1[1]);
        check("rpt.down_pulse", down_pulse1, m_w1[1] & ~m_w1[0]);
        check("rpt.up_level",   up_level1,   m_lvl[0]);
        check("rpt.down_level", down_level1, m_lvl[1]);
        check("one.up_pulse",   up_pulse0,   m_w0[0] & ~m_w0[1]);
        check("one.down_pulse", down_pulse0, m_w0[1] & ~m_w0[0]);
        check("one.up_level",   up_level0,   m_lvl[0]);
        check("one.down_level", down_level0, m_lvl[1]);
        up_cnt1   += int'(up_pulse1);
        down_cnt1 += int'(down_pulse1);
        up_cnt0   += int'(up_pulse0);
        down_cnt0 += int'(down_pulse0);
    endtask

    task automatic hold(input bit u, input bit d, input int n);
        for (int i = 0; i < n; i++) cycle(u, d, 1'b1);
    endtask

    task automatic clear_counts();
        up_cnt1 = 0; down_cnt1 = 0; up_cnt0 = 0; down_cnt0 = 0;
    endtask

    initial begin
        int n;
        bit u, d;
        clear_counts();

        // reset held with both buttons pressed, then simultaneous rise
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0);
        hold(1'b1, 1'b1, 8);
        hold(1'b0, 1'b0, 8);
        check("conflict.up_count", up_cnt1 == 0, 1'b1);

        // single press
        clear_counts();
        hold(1'b1, 1'b0, 8);
        hold(1'b0, 1'b0, 8);
        check("single.up_count", up_cnt1 == 1, 1'b1);

        // bounce then clean press
        clear_counts();
        hold(1'b1, 1'b0, 1); hold(1'b0, 1'b0, 1);
        hold(1'b1, 1'b0, 1); hold(1'b0, 1'b0, 1);
        hold(1'b1, 1'b0, 2); hold(1'b0, 1'b0, 6);
        check("bounce.up_count", up_cnt1 == 0, 1'b1);
        hold(1'b1, 1'b0, 6); hold(1'b0, 1'b0, 8);
        check("clean.up_count", up_cnt1 == 1, 1'b1);

        // auto-repeat: pulses at f, f+10, f+15 .. f+40
        clear_counts();
        hold(1'b0, 1'b1, 43);
        hold(1'b0, 1'b0, 10);
        check("repeat.down_count", down_cnt1 == 8, 1'b1);
        check("norepeat.down_count", down_cnt0 == 1, 1'b1);

        // staggered presses
        clear_counts();
        hold(1'b1, 1'b0, 2);
        hold(1'b1, 1'b1, 8);
        hold(1'b0, 1'b0, 10);
        check("stagger.counts", (up_cnt1 == 1) && (down_cnt1 == 1), 1'b1);

        // reset in the middle of repeating
        hold(1'b1, 1'b0, 20);
        cycle(1'b1, 1'b0, 1'b0);
        hold(1'b1, 1'b0, 25);
        hold(1'b0, 1'b0, 8);

        // randomized segments
        for (int s = 0; s < 120; s++) begin
            u = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
            n = int'($urandom_range(1, 30));
            if ($urandom_range(0, 14) == 0) cycle(u, d, 1'b0);
            hold(u, d, n);
        end
        hold(1'b0, 1'b0, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream stage of the up/down 7-segment counter controller.
- Conditions two raw mechanical push-buttons (up, down) for that controller: 2-FF synchronisation, per-button debounce, rising-edge detection and optional hold-to-auto-repeat.
- Emits single-cycle up_pulse/down_pulse strobes that drive the controller's up/down inputs directly.

Parameters:
- DB_CYCLES, 2500000: consecutive cycles a synchronised input must differ from its debounced level before that level flips (20 ms at 125 MHz).
- RPT_EN, 1: 1 enables auto-repeat while a button is held; 0 gives one pulse per press.
- RPT_DELAY, 62500000: cycles of debounced-high before the first repeat pulse (0.5 s).
- RPT_PERIOD, 12500000: cycles between subsequent repeat pulses (0.1 s).
- CNT_W, 26: counter width. Must hold max(DB_CYCLES, RPT_DELAY, RPT_PERIOD).

Ports:
- clk, in, 1: single system clock, rising edge.
- rst, in, 1: synchronous reset, active-low. rst==0 at a clk edge resets all state.
- up_raw, in, 1: raw up button, asynchronous, active-high.
- down_raw, in, 1: raw down button, asynchronous, active-high.
- up_pulse, out, 1: one-cycle up strobe.
- down_pulse, out, 1: one-cycle down strobe.
- up_level, out, 1: debounced up level.
- down_level, out, 1: debounced down level.

Behaviour:
- Reset (rst==0 at an edge) clears all of the following to 0: sync flops, debounced levels, debounce counters, repeat counters, FSMs (to IDLE), and all four outputs. Reset in the middle of a press or repeat aborts it. After release of reset, a button that is still high must complete a full debounce before it pulses.
- The two button channels are identical and independent apart from the conflict rule below. Outputs are registered.
- Synchroniser per channel: s1<=raw; s2<=s1.
- Debounce per channel:
  - If s2==db: cnt<=0.
  - Otherwise, if cnt==DB_CYCLES-1: db<=s2 and cnt<=0 (flip).
  - Otherwise: cnt<=cnt+1.
  - Any glitch shorter than DB_CYCLES consecutive cycles never changes db.
- Latency: raw first sampled high at edge k and held high → db flips at edge k+1+DB_CYCLES. The rising-edge pulse is registered at that same edge, so the pulse is high for exactly the following cycle.
- Per-channel FSM:
  - IDLE (db=0): on the 0→1 flip, raise the pulse and go to HELD, rcnt<=0.
  - HELD: rcnt counts every cycle. When RPT_EN=1 and rcnt==RPT_DELAY-1: pulse, rcnt<=0, go to REPEAT.
  - REPEAT: when rcnt==RPT_PERIOD-1: pulse, rcnt<=0.
  - HELD or REPEAT: db 1→0 flip → IDLE, rcnt<=0, no pulse. Release never pulses.
  - RPT_EN=0: HELD is terminal until release.
- Conflict rule: if both channels would pulse in the same cycle, both are suppressed, i.e. both output 0. Channel FSM and counters advance as if each had pulsed. Pulses in different cycles pass through unaffected.
- Pulse width is exactly 1 cycle. The same channel never pulses on two consecutive cycles, for any parameter values ≥2.
- up_level/down_level equal the registered db values, with no extra delay.
- rcnt saturates only via FSM reset; it never wraps inside HELD or REPEAT.

Test Plan (DB_CYCLES=4, RPT_DELAY=10, RPT_PERIOD=5, RPT_EN=1 unless stated):
- Reset check: hold rst=0 for 3 cycles with up_raw=down_raw=1 → all outputs 0 throughout. Release rst at edge r → up_level=1 after edge r+5; no pulses before that edge.
- Single press: up_raw 0→1 sampled at edge k, held 8 cycles, then 0 → up_pulse high only in the cycle after edge k+5; up_level rises at k+5 and falls 5 edges after release; down_pulse stays 0.
- Bounce rejection: up_raw toggles 1,0,1,0 on consecutive cycles, then 1 for 2 cycles, then 0 → no up_pulse, up_level stays 0. Follow with a clean 6-cycle press → exactly one up_pulse.
- Auto-repeat: down_raw held high 40 cycles after the flip at edge f → down_pulse at f, f+10, f+15, f+20, f+25, f+30, f+35, f+40. Rerun with RPT_EN=0 → one pulse only.
- Conflict: up_raw and down_raw rise on the same edge → no pulses at the flip edge and both levels=1. Rise down_raw 2 cycles after up_raw → up_pulse, then down_pulse 2 cycles later.
- Mid-repeat reset: rst=0 for one edge during REPEAT with up_raw still high → up_pulse=0 immediately. Next up_pulse occurs DB_CYCLES+1 edges after reset release, then repeats resume on the RPT_DELAY timing.
